// File: rtl/mem_stage_wb_master_if.sv
// rtl/mem_stage_wb_master_if.sv - pipeline request and Wishbone bus bundle for the MEM-stage master
interface mem_stage_wb_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    req_valid_i;
  logic                    req_we_i;
  logic [ADDR_WIDTH-1:0]   req_addr_i;
  logic [DATA_WIDTH-1:0]   req_wdata_i;
  logic [1:0]              req_size_i;
  logic                    req_unsigned_i;
  logic                    stall_o;
  logic                    rsp_valid_o;
  logic [DATA_WIDTH-1:0]   rsp_rdata_o;
  logic                    misalign_o;
  logic                    bus_err_o;
  logic                    wb_cyc_o;
  logic                    wb_stb_o;
  logic                    wb_ack_i;
  logic                    wb_we_o;
  logic [ADDR_WIDTH-1:0]   wb_adr_o;
  logic [DATA_WIDTH-1:0]   wb_dat_o;
  logic [DATA_WIDTH-1:0]   wb_dat_i;
  logic [3:0]              wb_sel_o;

  modport master (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_size_i, req_unsigned_i,
    input  wb_ack_i, wb_dat_i,
    output stall_o, rsp_valid_o, rsp_rdata_o, misalign_o, bus_err_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
  );

  modport slave (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_size_i, req_unsigned_i,
    output wb_ack_i, wb_dat_i,
    input  stall_o, rsp_valid_o, rsp_rdata_o, misalign_o, bus_err_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
  );
endinterface

// File: rtl/mem_stage_wb_master.sv
// rtl/mem_stage_wb_master.sv - MEM-stage load/store to Wishbone classic cycle master
module mem_stage_wb_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                   clk_i,
  input logic                   rst_i,
  mem_stage_wb_master_if.master bus
);
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUS  = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;
  localparam int         CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]            r_state;
  logic                  r_cyc;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [DATA_WIDTH-1:0] r_dat;
  logic [3:0]            r_sel;
  logic [CNT_W-1:0]      r_cnt;
  logic [1:0]            r_addr_lo;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic                  r_rsp_valid;
  logic                  r_bus_err;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_idle;
  logic                  w_misalign;
  logic                  w_start;
  logic [3:0]            w_sel;
  logic [DATA_WIDTH-1:0] w_wdat;
  logic [DATA_WIDTH-1:0] w_shift;
  logic [DATA_WIDTH-1:0] w_ext;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_misalign = (bus.req_size_i == 2'b11) ||
                      (bus.req_size_i == 2'b01 && bus.req_addr_i[0]) ||
                      (bus.req_size_i == 2'b10 && bus.req_addr_i[1:0] != 2'b00);
  assign w_start    = w_idle && bus.req_valid_i && !w_misalign;

  // Byte-lane selects and lane-replicated store data for the incoming request
  always_comb begin
    w_sel  = 4'b0000;
    w_wdat = bus.req_wdata_i;
    case (bus.req_size_i)
      2'b00: begin
        w_sel  = 4'b0001 << bus.req_addr_i[1:0];
        w_wdat = {4{bus.req_wdata_i[7:0]}};
      end
      2'b01: begin
        w_sel  = 4'b0011 << {bus.req_addr_i[1], 1'b0};
        w_wdat = {2{bus.req_wdata_i[15:0]}};
      end
      2'b10: w_sel = 4'b1111;
      default: w_sel = 4'b0000;
    endcase
  end

  // Bring the addressed lane down to bit 0, then mask and extend to the access size
  assign w_shift = bus.wb_dat_i >> {r_addr_lo, 3'b000};
  always_comb begin
    w_ext = w_shift;
    case (r_size)
      2'b00:   w_ext = r_unsigned ? {24'd0, w_shift[7:0]}  : {{24{w_shift[7]}}, w_shift[7:0]};
      2'b01:   w_ext = r_unsigned ? {16'd0, w_shift[15:0]} : {{16{w_shift[15]}}, w_shift[15:0]};
      default: w_ext = w_shift;
    endcase
  end

  // Request/bus/response sequencer; reset drops the bus cycle without a response
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_sel       <= 4'b0000;
      r_cnt       <= '0;
      r_addr_lo   <= 2'b00;
      r_size      <= 2'b00;
      r_unsigned  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_bus_err   <= 1'b0;
      r_rdata     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_cyc      <= 1'b1;
            r_we       <= bus.req_we_i;
            r_adr      <= {bus.req_addr_i[ADDR_WIDTH-1:2], 2'b00};
            r_sel      <= w_sel;
            r_dat      <= w_wdat;
            r_cnt      <= '0;
            r_addr_lo  <= bus.req_addr_i[1:0];
            r_size     <= bus.req_size_i;
            r_unsigned <= bus.req_unsigned_i;
            r_state    <= ST_BUS;
          end
        end
        ST_BUS: begin
          if (bus.wb_ack_i) begin
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_sel       <= 4'b0000;
            r_rdata     <= r_we ? '0 : w_ext;
            r_bus_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else if (r_cnt == CNT_LAST) begin
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_sel       <= 4'b0000;
            r_rdata     <= '0;
            r_bus_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          r_rsp_valid <= 1'b0;
          r_bus_err   <= 1'b0;
          r_rdata     <= '0;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.stall_o     = w_start || (r_state == ST_BUS);
  assign bus.misalign_o  = w_idle && bus.req_valid_i && w_misalign;
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_rdata_o = r_rdata;
  assign bus.bus_err_o   = r_bus_err;
  assign bus.wb_cyc_o    = r_cyc;
  assign bus.wb_stb_o    = r_cyc;
  assign bus.wb_we_o     = r_we;
  assign bus.wb_adr_o    = r_adr;
  assign bus.wb_dat_o    = r_dat;
  assign bus.wb_sel_o    = r_sel;
endmodule

// File: tb/tb_mem_stage_wb_master.sv
// tb/tb_mem_stage_wb_master.sv - vector table and scoreboard bench for mem_stage_wb_master
module tb_mem_stage_wb_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mem_stage_wb_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus();

  mem_stage_wb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(255)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.master)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] rdat;
    int          delay;
    logic        mis;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  vec_t vecs[12];
  rsp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard: every response pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid_o) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        rsp_t e;
        e = sb.pop_front();
        check("rsp_rdata", bus.rsp_rdata_o, e.rdata);
        check("rsp_err", {31'd0, bus.bus_err_o}, {31'd0, e.err});
      end
    end
  end

  task automatic drive_req(input vec_t v);
    bus.req_valid_i    = 1'b1;
    bus.req_we_i       = v.we;
    bus.req_addr_i     = v.addr;
    bus.req_wdata_i    = v.wdata;
    bus.req_size_i     = v.size;
    bus.req_unsigned_i = v.uns;
  endtask

  task automatic run_vec(input vec_t v);
    rsp_t e;
    @(negedge clk);
    drive_req(v);
    #1;
    if (v.mis) begin
      check("mis_pulse", {31'd0, bus.misalign_o}, 32'd1);
      check("mis_stall", {31'd0, bus.stall_o}, 32'd0);
      @(posedge clk); #1;
      bus.req_valid_i = 1'b0;
      check("mis_nocyc", {31'd0, bus.wb_cyc_o}, 32'd0);
      return;
    end
    check("req_stall", {31'd0, bus.stall_o}, 32'd1);
    check("req_nomis", {31'd0, bus.misalign_o}, 32'd0);
    e.rdata = v.rdata;
    e.err   = 1'b0;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    check("cyc", {30'd0, bus.wb_cyc_o, bus.wb_stb_o}, 32'd3);
    check("we", {31'd0, bus.wb_we_o}, {31'd0, v.we});
    check("adr", bus.wb_adr_o, v.addr & 32'hFFFF_FFFC);
    check("sel", {28'd0, bus.wb_sel_o}, {28'd0, v.sel});
    check("dat_o", bus.wb_dat_o, v.dat);
    for (int i = 0; i < v.delay; i++) begin
      @(posedge clk); #1;
      check("wait_cyc", {31'd0, bus.wb_cyc_o}, 32'd1);
      check("wait_stall", {31'd0, bus.stall_o}, 32'd1);
      check("wait_sel", {28'd0, bus.wb_sel_o}, {28'd0, v.sel});
      check("wait_dat", bus.wb_dat_o, v.dat);
    end
    bus.wb_dat_i = v.rdat;
    bus.wb_ack_i = 1'b1;
    @(posedge clk); #1;
    bus.wb_ack_i = 1'b0;
    check("ack_cyc", {31'd0, bus.wb_cyc_o}, 32'd0);
    check("resp_stall", {31'd0, bus.stall_o}, 32'd0);
    check("resp_valid", {31'd0, bus.rsp_valid_o}, 32'd1);
    @(posedge clk); #1;
    check("resp_one", {31'd0, bus.rsp_valid_o}, 32'd0);
  endtask

  initial begin
    vec_t v;
    rsp_t e;
    int   n;

    bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_addr_i = '0;
    bus.req_wdata_i = '0;   bus.req_size_i = 2'b00; bus.req_unsigned_i = 1'b0;
    bus.wb_ack_i = 1'b0;    bus.wb_dat_i = '0;

    //          we    addr          wdata         sz     uns   rdat          dly mis   sel      dat           rdata
    vecs[0]  = '{1'b1, 32'h80000003, 32'h000000AB, 2'b00, 1'b0, 32'h0,        4, 1'b0, 4'b1000, 32'hABABABAB, 32'h0};
    vecs[1]  = '{1'b0, 32'h80000002, 32'h0,        2'b00, 1'b0, 32'h12F45678, 1, 1'b0, 4'b0100, 32'h0,        32'hFFFFFFF4};
    vecs[2]  = '{1'b0, 32'h80000002, 32'h0,        2'b00, 1'b1, 32'h12F45678, 0, 1'b0, 4'b0100, 32'h0,        32'h000000F4};
    vecs[3]  = '{1'b0, 32'h80000006, 32'h0,        2'b01, 1'b0, 32'h8001CAFE, 2, 1'b0, 4'b1100, 32'h0,        32'hFFFF8001};
    vecs[4]  = '{1'b0, 32'h80000004, 32'h0,        2'b10, 1'b0, 32'h8001CAFE, 0, 1'b0, 4'b1111, 32'h0,        32'h8001CAFE};
    vecs[5]  = '{1'b0, 32'h80000002, 32'h0,        2'b10, 1'b0, 32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[6]  = '{1'b0, 32'h80000001, 32'h0,        2'b01, 1'b0, 32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[7]  = '{1'b0, 32'h80000000, 32'h0,        2'b11, 1'b0, 32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[8]  = '{1'b1, 32'h80000002, 32'h1234BEEF, 2'b01, 1'b0, 32'hFFFFFFFF, 1, 1'b0, 4'b1100, 32'hBEEFBEEF, 32'h0};
    vecs[9]  = '{1'b1, 32'h8000000C, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0,        3, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h0};
    vecs[10] = '{1'b0, 32'h80000000, 32'h0,        2'b01, 1'b1, 32'h0000F00D, 0, 1'b0, 4'b0011, 32'h0,        32'h0000F00D};
    vecs[11] = '{1'b0, 32'h80000001, 32'h0,        2'b00, 1'b0, 32'h00007F00, 2, 1'b0, 4'b0010, 32'h0,        32'h0000007F};

    #1;
    check("rst_cyc", {30'd0, bus.wb_cyc_o, bus.wb_stb_o}, 32'd0);
    check("rst_rsp", {30'd0, bus.rsp_valid_o, bus.bus_err_o}, 32'd0);
    check("rst_rdata", bus.rsp_rdata_o, 32'd0);
    check("rst_adr", bus.wb_adr_o, 32'd0);
    check("rst_dat", bus.wb_dat_o, 32'd0);
    check("rst_sel", {28'd0, bus.wb_sel_o}, 32'd0);
    check("rst_stall", {31'd0, bus.stall_o}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Timeout: no ack, cycle held for exactly 255 cycles then aborted with error
    v = vecs[4];
    @(negedge clk);
    drive_req(v);
    e.rdata = 32'd0;
    e.err   = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    n = 0;
    while (bus.wb_cyc_o && n < 400) begin
      n++;
      @(posedge clk); #1;
    end
    check("to_cycles", n, 32'd255);
    check("to_valid", {30'd0, bus.rsp_valid_o, bus.bus_err_o}, 32'd3);
    check("to_rdata", bus.rsp_rdata_o, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    bus.wb_ack_i = 1'b1;
    @(posedge clk); #1;
    bus.wb_ack_i = 1'b0;
    check("late_ack_cyc", {31'd0, bus.wb_cyc_o}, 32'd0);
    check("late_ack_rsp", {31'd0, bus.rsp_valid_o}, 32'd0);

    // Reset mid-BUS: cycle drops at once and no response follows
    @(negedge clk);
    drive_req(vecs[1]);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    check("pre_rst_cyc", {31'd0, bus.wb_cyc_o}, 32'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("async_cyc", {30'd0, bus.wb_cyc_o, bus.wb_stb_o}, 32'd0);
    check("async_stall", {31'd0, bus.stall_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("post_rst_rsp", {31'd0, bus.rsp_valid_o}, 32'd0);
    end
    run_vec(vecs[3]);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
